rvc_eot_snap: RTL and testbench

RVC_EOT_SNAP -- requirements
Module: rvc_eot_snap

---
 rtl/rvc_eot_snap.sv | 119 +++++++++++
 tb/tb_rvc_eot_snap.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_eot_snap.sv
// End-of-test snapshot engine: on ebreak, halts the core, drains the pipeline
// and streams the whole data memory out one word at a time over a valid/ready port.
module rvc_eot_snap #(
  parameter logic [31:0] EBREAK_OPCODE = 32'h00100073,
  parameter logic [31:0] D_MEM_OFFSET  = 32'h00001000,
  parameter int          MSB_D_MEM     = 11,
  parameter int          DRAIN_CYCLES  = 4
) (
  input  logic        Clock,
  input  logic        RstN,
  input  logic [31:0] Instruction,
  input  logic        InstValid,
  output logic        Halt,
  output logic        SnapRdEn,
  output logic [31:0] SnapRdAddr,
  input  logic [31:0] SnapRdData,
  output logic        SnapValid,
  output logic [31:0] SnapAddr,
  output logic [31:0] SnapData,
  input  logic        SnapReady,
  output logic        EotDone
);

  // state | meaning
  // IDLE  | core running, watching for ebreak
  // DRAIN | core halted, letting in-flight stores settle
  // READ  | read strobe for the current word
  // WAIT  | read data returns, captured into the snapshot register
  // SEND  | word offered to the consumer until accepted
  // DONE  | dump finished, frozen until reset
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [31:0] SIZE_D_MEM = 32'(2 ** (MSB_D_MEM + 1));
  localparam logic [31:0] LAST_ADDR  = D_MEM_OFFSET + SIZE_D_MEM - 32'd4;
  localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES);

  state_t      state;
  logic [31:0] addr;
  logic [31:0] drain_cnt;

  // Outputs are registered alongside the state so each one changes on the
  // same edge as the state that owns it.
  always_ff @(posedge Clock or negedge RstN) begin
    if (!RstN) begin
      state      <= IDLE;
      addr       <= D_MEM_OFFSET;
      drain_cnt  <= '0;
      Halt       <= 1'b0;
      SnapRdEn   <= 1'b0;
      SnapRdAddr <= '0;
      SnapValid  <= 1'b0;
      SnapAddr   <= '0;
      SnapData   <= '0;
      EotDone    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InstValid && (Instruction == EBREAK_OPCODE)) begin
            state     <= DRAIN;
            Halt      <= 1'b1;
            drain_cnt <= DRAIN_LOAD;
            addr      <= D_MEM_OFFSET;
          end
        end
        DRAIN: begin
          // terminal count at zero, so DRAIN_CYCLES=0 still spends one cycle here
          if (drain_cnt == '0) begin
            state      <= READ;
            SnapRdEn   <= 1'b1;
            SnapRdAddr <= addr;
          end else begin
            drain_cnt <= drain_cnt - 32'd1;
          end
        end
        READ: begin
          state    <= WAIT;
          SnapRdEn <= 1'b0;
        end
        WAIT: begin
          state     <= SEND;
          SnapData  <= SnapRdData;
          SnapAddr  <= addr;
          SnapValid <= 1'b1;
        end
        SEND: begin
          if (SnapReady) begin
            SnapValid <= 1'b0;
            if (addr == LAST_ADDR) begin
              state   <= DONE;
              EotDone <= 1'b1;
            end else begin
              state      <= READ;
              addr       <= addr + 32'd4;
              SnapRdEn   <= 1'b1;
              SnapRdAddr <= addr + 32'd4;
            end
          end
        end
        DONE: begin
          Halt      <= 1'b1;
          EotDone   <= 1'b1;
          SnapValid <= 1'b0;
          SnapRdEn  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_eot_snap.sv
// Bench for rvc_eot_snap: ebreak detection table, timing and hold sequences,
// mid-dump reset, and a randomized dump checked against an expected-word queue.
module tb_rvc_eot_snap;

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] BASE   = 32'h00001000;
  localparam int          NWORDS = 1024;

  logic        Clock = 1'b0;
  logic        RstN;
  logic [31:0] Instruction;
  logic        InstValid;
  logic        Halt;
  logic        SnapRdEn;
  logic [31:0] SnapRdAddr;
  logic [31:0] SnapRdData;
  logic        SnapValid;
  logic [31:0] SnapAddr;
  logic [31:0] SnapData;
  logic        SnapReady;
  logic        EotDone;

  rvc_eot_snap dut (
    .Clock      (Clock),
    .RstN       (RstN),
    .Instruction(Instruction),
    .InstValid  (InstValid),
    .Halt       (Halt),
    .SnapRdEn   (SnapRdEn),
    .SnapRdAddr (SnapRdAddr),
    .SnapRdData (SnapRdData),
    .SnapValid  (SnapValid),
    .SnapAddr   (SnapAddr),
    .SnapData   (SnapData),
    .SnapReady  (SnapReady),
    .EotDone    (EotDone)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc = 0;
  int bad_tp = 0;
  int inv_bad = 0;
  int bad_rd = 0;
  logic mon_en = 1'b0;
  logic tp_check = 1'b0;

  logic [31:0] mem [NWORDS];
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        exp_halt;
  } vec_t;
  vec_t vecs [6];

  always @(posedge Clock) cyc <= cyc + 1;

  // Data memory with one-cycle read latency; garbage when not reading.
  always @(posedge Clock) begin
    if (SnapRdEn) begin
      if (SnapRdAddr < BASE || SnapRdAddr >= BASE + 32'(NWORDS * 4) || SnapRdAddr[1:0] != 2'b00) begin
        bad_rd <= bad_rd + 1;
        SnapRdData <= 32'hBAD0BAD0;
      end else begin
        SnapRdData <= mem[(SnapRdAddr - BASE) >> 2];
      end
    end else begin
      SnapRdData <= $urandom;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Acceptance monitor and output invariants, sampled mid-cycle.
  always @(negedge Clock) begin
    if (mon_en && RstN) begin
      if (SnapValid && SnapReady) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual_addr=%h required=none", SnapAddr);
        end else begin
          check32("snap_addr", SnapAddr, exp_addr_q.pop_front());
          check32("snap_data", SnapData, exp_data_q.pop_front());
        end
        if (tp_check && acc_cnt > 0 && (cyc - last_acc) != 3) bad_tp++;
        last_acc = cyc;
        acc_cnt++;
      end
      if (SnapValid && SnapRdEn) inv_bad++;
      if ((SnapValid || SnapRdEn || EotDone) && !Halt) inv_bad++;
      if (EotDone && (SnapValid || SnapRdEn)) inv_bad++;
    end
  end

  task automatic do_reset();
    @(posedge Clock); #1;
    RstN = 1'b0; InstValid = 1'b0; Instruction = NOP; SnapReady = 1'b0;
    repeat (2) @(posedge Clock);
    #1 RstN = 1'b1;
  endtask

  task automatic build_expect();
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < NWORDS; i++) begin
      exp_addr_q.push_back(BASE + 32'(i * 4));
      exp_data_q.push_back(mem[i]);
    end
    acc_cnt = 0;
    bad_tp = 0;
  endtask

  // Issue ebreak, check Halt next cycle and first read five edges after capture.
  task automatic start_dump();
    int t0;
    int n;
    @(posedge Clock); #1;
    Instruction = EBREAK; InstValid = 1'b1;
    @(posedge Clock); #1;
    t0 = cyc; InstValid = 1'b0; Instruction = NOP;
    @(negedge Clock);
    check32("halt_after_ebreak", 32'(Halt), 32'd1);
    n = 0;
    while (!SnapRdEn && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check32("first_rd_delay", 32'(cyc - t0), 32'd5);
    check32("first_rd_addr", SnapRdAddr, BASE);
  endtask

  task automatic finish_dump(input string tag);
    int n;
    n = 0;
    while (!EotDone && n < 20000) begin
      @(negedge Clock);
      n++;
    end
    check32({tag, "_eot_seen"}, 32'(EotDone), 32'd1);
    check32({tag, "_eot_delay"}, 32'(cyc - last_acc), 32'd1);
    check32({tag, "_word_count"}, 32'(acc_cnt), 32'(NWORDS));
    check32({tag, "_left_in_queue"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    int hold_bad;
    logic [31:0] a0;
    logic [31:0] d0;

    RstN = 1'b0; InstValid = 1'b0; Instruction = NOP; SnapReady = 1'b0;
    #2;
    check32("rst_halt", 32'(Halt), 32'd0);
    check32("rst_rden", 32'(SnapRdEn), 32'd0);
    check32("rst_valid", 32'(SnapValid), 32'd0);
    check32("rst_eot", 32'(EotDone), 32'd0);
    check32("rst_rdaddr", SnapRdAddr, 32'd0);
    check32("rst_snapaddr", SnapAddr, 32'd0);
    check32("rst_snapdata", SnapData, 32'd0);

    // Ebreak detection table
    vecs[0] = '{instr: EBREAK,       valid: 1'b0, exp_halt: 1'b0};
    vecs[1] = '{instr: NOP,          valid: 1'b1, exp_halt: 1'b0};
    vecs[2] = '{instr: 32'h00100072, valid: 1'b1, exp_halt: 1'b0};
    vecs[3] = '{instr: 32'h80100073, valid: 1'b1, exp_halt: 1'b0};
    vecs[4] = '{instr: 32'h00000073, valid: 1'b1, exp_halt: 1'b0};
    vecs[5] = '{instr: EBREAK,       valid: 1'b1, exp_halt: 1'b1};
    for (int v = 0; v < 6; v++) begin
      do_reset();
      @(posedge Clock); #1;
      Instruction = vecs[v].instr; InstValid = vecs[v].valid;
      @(posedge Clock); #1;
      Instruction = NOP; InstValid = 1'b0;
      @(negedge Clock);
      check32($sformatf("vec%0d_halt", v), 32'(Halt), 32'(vecs[v].exp_halt));
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge Clock);
        if (SnapRdEn) seen++;
      end
      check32($sformatf("vec%0d_read_seen", v), 32'(seen != 0), 32'(vecs[v].exp_halt));
    end

    // Memory holds its own address; hold first word for 20 cycles, then stream.
    do_reset();
    for (int i = 0; i < NWORDS; i++) mem[i] = BASE + 32'(i * 4);
    build_expect();
    tp_check = 1'b1;
    mon_en = 1'b1;
    start_dump();
    n = 0;
    while (!SnapValid && n < 20) begin
      @(negedge Clock);
      n++;
    end
    a0 = SnapAddr; d0 = SnapData;
    check32("hold_first_addr", a0, BASE);
    check32("hold_first_data", d0, BASE);
    hold_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      if (!SnapValid || SnapAddr !== a0 || SnapData !== d0) hold_bad++;
    end
    check32("hold_stable_cycles_bad", 32'(hold_bad), 32'd0);
    @(posedge Clock); #1 SnapReady = 1'b1;
    @(negedge Clock);
    check32("hold_valid_at_accept", 32'(SnapValid), 32'd1);
    @(negedge Clock);
    check32("hold_valid_after_accept", 32'(SnapValid), 32'd0);
    finish_dump("addr_mem");
    check32("addr_mem_throughput_bad", 32'(bad_tp), 32'd0);
    mon_en = 1'b0;

    // Reset in the middle of SEND for word 0x1010, then restart from the base.
    do_reset();
    SnapReady = 1'b1;
    start_dump();
    n = 0;
    while (!(SnapValid && SnapAddr == BASE + 32'h10) && n < 100) begin
      @(negedge Clock);
      n++;
    end
    check32("midsend_reached", SnapAddr, BASE + 32'h10);
    RstN = 1'b0;
    #1;
    check32("abort_halt", 32'(Halt), 32'd0);
    check32("abort_valid", 32'(SnapValid), 32'd0);
    check32("abort_rden", 32'(SnapRdEn), 32'd0);
    check32("abort_outs", SnapAddr | SnapData | SnapRdAddr | 32'(EotDone), 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge Clock);
      if (SnapValid || SnapRdEn) seen++;
    end
    @(posedge Clock); #1 RstN = 1'b1;
    repeat (10) begin
      @(negedge Clock);
      if (SnapValid || SnapRdEn || Halt) seen++;
    end
    check32("abort_quiet_cycles", 32'(seen), 32'd0);
    build_expect();
    tp_check = 1'b1;
    mon_en = 1'b1;
    start_dump();
    finish_dump("restart");
    check32("restart_throughput_bad", 32'(bad_tp), 32'd0);
    mon_en = 1'b0;

    // Random memory, random ready, noisy instruction stream with stray ebreaks.
    do_reset();
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
    build_expect();
    tp_check = 1'b0;
    mon_en = 1'b1;
    start_dump();
    n = 0;
    while (!EotDone && n < 30000) begin
      @(posedge Clock); #1;
      SnapReady = 1'($urandom_range(0, 1));
      InstValid = 1'($urandom_range(0, 1));
      Instruction = ($urandom_range(0, 3) == 0) ? EBREAK : ($urandom & 32'hFFEF_FFFF);
      n++;
    end
    finish_dump("random");
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge Clock); #1;
      SnapReady = 1'($urandom_range(0, 1));
      InstValid = 1'b1;
      Instruction = EBREAK;
      @(negedge Clock);
      if (!EotDone || !Halt || SnapValid || SnapRdEn) seen++;
    end
    check32("done_sticky_bad", 32'(seen), 32'd0);
    check32("done_no_extra_words", 32'(acc_cnt), 32'(NWORDS));
    mon_en = 1'b0;

    check32("invariant_violations", 32'(inv_bad), 32'd0);
    check32("read_addr_out_of_range", 32'(bad_rd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
